// File: rtl/utils_pkg.sv
// Shared types and constants for the machine interrupt sources and the CSR trap logic.
// Holds the interrupt bundle, the timer register offsets and a byte-strobe merge helper.
package utils_pkg;

   typedef struct packed {
      logic ext_irq;
      logic sw_irq;
      logic timer_irq;
   } s_irq_t;

   localparam logic [31:0] IRQT_MTIME_LO    = 32'h00;
   localparam logic [31:0] IRQT_MTIME_HI    = 32'h04;
   localparam logic [31:0] IRQT_MTIMECMP_LO = 32'h08;
   localparam logic [31:0] IRQT_MTIMECMP_HI = 32'h0C;
   localparam logic [31:0] IRQT_MSIP        = 32'h10;
   localparam logic [31:0] IRQT_PRESC       = 32'h14;

   typedef enum logic {
      IRQT_IDLE,
      IRQT_RESP
   } irqt_fsm_t;

   // Replace only the strobed bytes of old_val with the matching bytes of wdata.
   function automatic logic [31:0] irqt_apply_wstrb(input logic [31:0] old_val,
                                                    input logic [31:0] wdata,
                                                    input logic [3:0]  wstrb);
      logic [31:0] merged;
      merged = old_val;
      for (int i = 0; i < 4; i++) begin
         if (wstrb[i]) begin
            merged[8*i +: 8] = wdata[8*i +: 8];
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/irqt_sync.sv
// Multi-flop synchroniser for an asynchronous level input; output resets low.
module irqt_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_reg <= '0;
      end else begin
         sync_reg <= {sync_reg[STAGES-2:0], d};
      end
   end

   assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/irq_timer_gen.sv
// Memory-mapped mtime/mtimecmp timer, MSIP software interrupt and synchronised external
// interrupt, presented to the CSR block as one s_irq_t bundle.
module irq_timer_gen
   import utils_pkg::*;
#(
   parameter int          ADDR_W        = 5,
   parameter logic [31:0] PRESCALER_RST = 32'd0,
   parameter int          SYNC_STAGES   = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [31:0]       req_wdata_i,
   input  logic [3:0]        req_wstrb_i,
   output logic              resp_valid_o,
   input  logic              resp_ready_i,
   output logic [31:0]       resp_rdata_o,
   output logic              resp_err_o,
   input  logic              ext_irq_i,
   output s_irq_t            irq_o
);

   irqt_fsm_t   state_reg;
   logic        req_ready_reg;
   logic        resp_valid_reg;
   logic        resp_err_reg;
   logic [31:0] resp_rdata_reg;

   logic [63:0] mtime_reg, mtime_next;
   logic [63:0] mtimecmp_reg, mtimecmp_next;
   logic        msip_reg, msip_next;
   logic [31:0] presc_reg, presc_next;
   logic [31:0] presc_cnt_reg, presc_cnt_next;
   logic [31:0] shadow_hi_reg, shadow_hi_next;
   logic        timer_irq_reg;
   logic        ext_irq_sync;

   logic [31:0] addr_ext;
   logic [31:0] rd_data;
   logic        accept, addr_err, wr_en, rd_en, wr_any, tick;

   assign addr_ext = 32'(req_addr_i);
   assign accept   = (state_reg == IRQT_IDLE) && req_valid_i;
   assign addr_err = (addr_ext[1:0] != 2'b00) || (addr_ext > IRQT_PRESC);
   assign wr_en    = accept && req_we_i && !addr_err;
   assign rd_en    = accept && !req_we_i && !addr_err;
   assign wr_any   = wr_en && (req_wstrb_i != 4'b0000);
   assign tick     = (presc_cnt_reg == presc_reg);

   always_comb begin
      rd_data = '0;
      case (addr_ext)
         IRQT_MTIME_LO:    rd_data = mtime_reg[31:0];
         IRQT_MTIME_HI:    rd_data = shadow_hi_reg;
         IRQT_MTIMECMP_LO: rd_data = mtimecmp_reg[31:0];
         IRQT_MTIMECMP_HI: rd_data = mtimecmp_reg[63:32];
         IRQT_MSIP:        rd_data = {31'b0, msip_reg};
         IRQT_PRESC:       rd_data = presc_reg;
         default:          rd_data = '0;
      endcase
   end

   // A software write to either mtime half replaces the tick for that cycle.
   always_comb begin
      mtime_next     = tick ? mtime_reg + 64'd1 : mtime_reg;
      mtimecmp_next  = mtimecmp_reg;
      msip_next      = msip_reg;
      presc_next     = presc_reg;
      presc_cnt_next = tick ? 32'd0 : presc_cnt_reg + 32'd1;
      shadow_hi_next = shadow_hi_reg;
      if (rd_en && (addr_ext == IRQT_MTIME_LO)) begin
         shadow_hi_next = mtime_reg[63:32];
      end
      if (wr_any) begin
         case (addr_ext)
            IRQT_MTIME_LO:
               mtime_next = {mtime_reg[63:32],
                             irqt_apply_wstrb(mtime_reg[31:0], req_wdata_i, req_wstrb_i)};
            IRQT_MTIME_HI:
               mtime_next = {irqt_apply_wstrb(mtime_reg[63:32], req_wdata_i, req_wstrb_i),
                             mtime_reg[31:0]};
            IRQT_MTIMECMP_LO:
               mtimecmp_next[31:0] = irqt_apply_wstrb(mtimecmp_reg[31:0], req_wdata_i, req_wstrb_i);
            IRQT_MTIMECMP_HI:
               mtimecmp_next[63:32] = irqt_apply_wstrb(mtimecmp_reg[63:32], req_wdata_i, req_wstrb_i);
            IRQT_MSIP: begin
               if (req_wstrb_i[0]) begin
                  msip_next = req_wdata_i[0];
               end
            end
            IRQT_PRESC: begin
               presc_next     = irqt_apply_wstrb(presc_reg, req_wdata_i, req_wstrb_i);
               presc_cnt_next = 32'd0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mtime_reg     <= '0;
         mtimecmp_reg  <= '1;
         msip_reg      <= 1'b0;
         presc_reg     <= PRESCALER_RST;
         presc_cnt_reg <= '0;
         shadow_hi_reg <= '0;
         timer_irq_reg <= 1'b0;
      end else begin
         mtime_reg     <= mtime_next;
         mtimecmp_reg  <= mtimecmp_next;
         msip_reg      <= msip_next;
         presc_reg     <= presc_next;
         presc_cnt_reg <= presc_cnt_next;
         shadow_hi_reg <= shadow_hi_next;
         timer_irq_reg <= (mtime_reg >= mtimecmp_reg);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= IRQT_IDLE;
         req_ready_reg  <= 1'b1;
         resp_valid_reg <= 1'b0;
         resp_rdata_reg <= '0;
         resp_err_reg   <= 1'b0;
      end else begin
         case (state_reg)
            IRQT_IDLE: begin
               if (req_valid_i) begin
                  state_reg      <= IRQT_RESP;
                  req_ready_reg  <= 1'b0;
                  resp_valid_reg <= 1'b1;
                  resp_rdata_reg <= rd_en ? rd_data : 32'd0;
                  resp_err_reg   <= addr_err;
               end
            end
            IRQT_RESP: begin
               if (resp_ready_i) begin
                  state_reg      <= IRQT_IDLE;
                  req_ready_reg  <= 1'b1;
                  resp_valid_reg <= 1'b0;
                  resp_rdata_reg <= '0;
                  resp_err_reg   <= 1'b0;
               end
            end
            default: state_reg <= IRQT_IDLE;
         endcase
      end
   end

   irqt_sync #(
      .STAGES(SYNC_STAGES)
   ) u_ext_sync (
      .clk(clk),
      .rst(rst),
      .d  (ext_irq_i),
      .q  (ext_irq_sync)
   );

   assign req_ready_o  = req_ready_reg;
   assign resp_valid_o = resp_valid_reg;
   assign resp_rdata_o = resp_rdata_reg;
   assign resp_err_o   = resp_err_reg;
   assign irq_o        = {ext_irq_sync, msip_reg, timer_irq_reg};

endmodule

// File: tb/tb_irq_timer_gen.sv
// Self-checking bench for irq_timer_gen: directed scenarios plus randomized bus traffic
// checked against a transaction-level model of the register map and timer.
module tb_irq_timer_gen;
   import utils_pkg::*;

   localparam int SYNC = 2;
   localparam logic [4:0] A_MT_LO  = 5'h00;
   localparam logic [4:0] A_MT_HI  = 5'h04;
   localparam logic [4:0] A_CMP_LO = 5'h08;
   localparam logic [4:0] A_CMP_HI = 5'h0C;
   localparam logic [4:0] A_MSIP   = 5'h10;
   localparam logic [4:0] A_PRESC  = 5'h14;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic        req_we_i = 1'b0;
   logic [4:0]  req_addr_i = '0;
   logic [31:0] req_wdata_i = '0;
   logic [3:0]  req_wstrb_i = '0;
   logic        resp_valid_o;
   logic        resp_ready_i = 1'b1;
   logic [31:0] resp_rdata_o;
   logic        resp_err_o;
   logic        ext_irq_i = 1'b0;
   s_irq_t      irq_o;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   irq_timer_gen #(
      .ADDR_W(5), .PRESCALER_RST(32'd0), .SYNC_STAGES(SYNC)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
      .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
      .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
      .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
      .ext_irq_i(ext_irq_i), .irq_o(irq_o)
   );

   // Reference model state
   logic [63:0] m_mtime, m_cmp;
   logic        m_msip, m_timer, m_busy, m_err;
   logic [31:0] m_presc, m_cnt, m_shadow, m_rdata;
   logic        ext_hist[$];

   function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] w, input logic [3:0] s);
      logic [31:0] r;
      for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? w[8*b +: 8] : o[8*b +: 8];
      return r;
   endfunction

   function automatic s_irq_t exp_irq();
      return {ext_hist[SYNC-1], m_msip, m_timer};
   endfunction

   task automatic model_reset();
      m_mtime = '0; m_cmp = '1; m_msip = 1'b0; m_presc = '0; m_cnt = '0; m_shadow = '0;
      m_timer = 1'b0; m_busy = 1'b0; m_err = 1'b0; m_rdata = '0;
      ext_hist = {};
      for (int i = 0; i < SYNC; i++) ext_hist.push_back(1'b0);
   endtask

   // One clock edge of the register map, using the bus inputs presented before the edge.
   task automatic model_edge();
      logic tick;
      logic [63:0] nt;
      logic [31:0] a, ncnt;
      if (!rst) return;
      tick = (m_cnt == m_presc);
      nt   = tick ? m_mtime + 64'd1 : m_mtime;
      ncnt = tick ? 32'd0 : m_cnt + 32'd1;
      ext_hist.push_front(ext_irq_i);
      void'(ext_hist.pop_back());
      if (m_busy) begin
         if (resp_ready_i) begin
            m_busy = 1'b0; m_rdata = '0; m_err = 1'b0;
         end
      end else if (req_valid_i) begin
         a = {27'b0, req_addr_i};
         m_busy = 1'b1; m_rdata = '0;
         m_err = (a % 4 != 0) || (a > 32'h14);
         if (!m_err && !req_we_i) begin
            case (a)
               32'h00: begin m_rdata = m_mtime[31:0]; m_shadow = m_mtime[63:32]; end
               32'h04: m_rdata = m_shadow;
               32'h08: m_rdata = m_cmp[31:0];
               32'h0C: m_rdata = m_cmp[63:32];
               32'h10: m_rdata = {31'b0, m_msip};
               default: m_rdata = m_presc;
            endcase
         end else if (!m_err && req_wstrb_i != 4'b0) begin
            case (a)
               32'h00: nt = {m_mtime[63:32], mrg(m_mtime[31:0], req_wdata_i, req_wstrb_i)};
               32'h04: nt = {mrg(m_mtime[63:32], req_wdata_i, req_wstrb_i), m_mtime[31:0]};
               32'h08: m_cmp[31:0]  = mrg(m_cmp[31:0], req_wdata_i, req_wstrb_i);
               32'h0C: m_cmp[63:32] = mrg(m_cmp[63:32], req_wdata_i, req_wstrb_i);
               32'h10: if (req_wstrb_i[0]) m_msip = req_wdata_i[0];
               default: begin m_presc = mrg(m_presc, req_wdata_i, req_wstrb_i); ncnt = 32'd0; end
            endcase
         end
      end
      m_timer = (m_mtime >= m_cmp);
      m_mtime = nt;
      m_cnt   = ncnt;
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_req(input logic we, input logic [4:0] addr, input logic [31:0] wd,
                         input logic [3:0] ws, output logic ov, output logic [31:0] ord,
                         output logic oerr, output logic [31:0] erd, output logic eerr,
                         output s_irq_t irq_acc);
      req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr; req_wdata_i = wd; req_wstrb_i = ws;
      resp_ready_i = 1'b1;
      cycle();
      req_valid_i = 1'b0;
      ov = resp_valid_o; ord = resp_rdata_o; oerr = resp_err_o;
      erd = m_rdata; eerr = m_err; irq_acc = irq_o;
      $display("txn we=%0d addr=%02h wdata=%08h wstrb=%h -> valid=%0d rdata=%08h err=%0d",
               we, addr, wd, ws, ov, ord, oerr);
      cycle();
   endtask

   task automatic test_reset();
      logic ov, oerr, eerr; logic [31:0] ord, erd; s_irq_t ia;
      rst = 1'b0;
      model_reset();
      cycle();
      total++;
      if ({req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, irq_o} !== {1'b1, 1'b0, 32'd0, 1'b0, 3'b000}) begin
         bad++; $display("FAIL reset_outputs: got rdy=%b v=%b rd=%h e=%b irq=%b", req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, irq_o);
      end
      cycle();
      @(negedge clk);
      rst = 1'b1;
      do_req(1'b0, A_CMP_HI, 32'd0, 4'h0, ov, ord, oerr, erd, eerr, ia);
      total++;
      if ({ov, oerr, ord} !== {1'b1, 1'b0, 32'hFFFF_FFFF}) begin
         bad++; $display("FAIL reset_cmp_hi: got v=%b e=%b rd=%h required v=1 e=0 rd=ffffffff", ov, oerr, ord);
      end
      total++;
      if (irq_o !== 3'b000) begin
         bad++; $display("FAIL reset_irq: got %b required 000", irq_o);
      end
   endtask

   task automatic test_timer();
      logic ov, oerr, eerr; logic [31:0] ord, erd; s_irq_t ia; int rise_k;
      do_req(1'b1, A_PRESC, 32'd0, 4'hF, ov, ord, oerr, erd, eerr, ia);
      do_req(1'b1, A_CMP_HI, 32'd0, 4'hF, ov, ord, oerr, erd, eerr, ia);
      do_req(1'b1, A_CMP_LO, 32'h14, 4'hF, ov, ord, oerr, erd, eerr, ia);
      do_req(1'b1, A_MT_LO, 32'h10, 4'hF, ov, ord, oerr, erd, eerr, ia);
      total++;
      if ({ov, oerr, ord} !== {1'b1, 1'b0, 32'd0}) begin
         bad++; $display("FAIL timer_write_resp: got v=%b e=%b rd=%h required v=1 e=0 rd=0", ov, oerr, ord);
      end
      rise_k = -1;
      for (int k = 0; k < 12; k++) begin
         cycle();
         total++;
         if (irq_o.timer_irq !== m_timer) begin
            bad++; $display("FAIL timer_level k=%0d: got %b required %b", k, irq_o.timer_irq, m_timer);
         end
         if (rise_k < 0 && irq_o.timer_irq === 1'b1) rise_k = k;
      end
      total++;
      if (rise_k != 3) begin
         bad++; $display("FAIL timer_rise_cycle: got %0d required 3", rise_k);
      end
      do_req(1'b1, A_CMP_LO, 32'h100, 4'hF, ov, ord, oerr, erd, eerr, ia);
      total++;
      if ({ia.timer_irq, irq_o.timer_irq} !== 2'b10) begin
         bad++; $display("FAIL timer_fall: got acc=%b after=%b required acc=1 after=0", ia.timer_irq, irq_o.timer_irq);
      end
   endtask

   task automatic test_presc();
      logic ov, oerr, eerr; logic [31:0] ord, erd, lo1; s_irq_t ia;
      do_req(1'b1, A_PRESC, 32'd3, 4'hF, ov, ord, oerr, erd, eerr, ia);
      do_req(1'b1, A_MT_HI, 32'hFFFF_FFFF, 4'hF, ov, ord, oerr, erd, eerr, ia);
      do_req(1'b1, A_MT_LO, 32'hFFFF_FFFF, 4'hF, ov, ord, oerr, erd, eerr, ia);
      total++;
      if ({ov, oerr} !== 2'b10) begin
         bad++; $display("FAIL presc_wrap_write: got v=%b e=%b required v=1 e=0", ov, oerr);
      end
      repeat (8) cycle();
      do_req(1'b0, A_MT_LO, 32'd0, 4'h0, ov, ord, oerr, erd, eerr, ia);
      lo1 = ord;
      total++;
      if ({oerr, ord} !== {eerr, erd}) begin
         bad++; $display("FAIL presc_mtime_lo: got %h required %h", ord, erd);
      end
      do_req(1'b0, A_MT_HI, 32'd0, 4'h0, ov, ord, oerr, erd, eerr, ia);
      total++;
      if ({oerr, ord} !== {1'b0, 32'd0}) begin
         bad++; $display("FAIL presc_wrapped_hi: got e=%b rd=%h required e=0 rd=0", oerr, ord);
      end
      repeat (4) cycle();
      do_req(1'b0, A_MT_LO, 32'd0, 4'h0, ov, ord, oerr, erd, eerr, ia);
      total++;
      if (ord - lo1 !== 32'd2) begin
         bad++; $display("FAIL presc_rate: got delta %0d over 8 clk required 2", ord - lo1);
      end
   endtask

   task automatic test_shadow();
      logic ov, oerr, eerr; logic [31:0] ord, erd; s_irq_t ia;
      do_req(1'b1, A_PRESC, 32'd7, 4'hF, ov, ord, oerr, erd, eerr, ia);
      do_req(1'b1, A_MT_HI, 32'd1, 4'hF, ov, ord, oerr, erd, eerr, ia);
      do_req(1'b1, A_MT_LO, 32'hFFFF_FFFF, 4'hF, ov, ord, oerr, erd, eerr, ia);
      for (int n = 0; n < 20 && m_cnt != m_presc; n++) cycle();
      total++;
      if (m_cnt !== m_presc) begin
         bad++; $display("FAIL shadow_align: tick not reached within 20 cycles");
      end
      do_req(1'b0, A_MT_LO, 32'd0, 4'h0, ov, ord, oerr, erd, eerr, ia);
      total++;
      if (ord !== 32'hFFFF_FFFF) begin
         bad++; $display("FAIL shadow_lo: got %h required ffffffff", ord);
      end
      do_req(1'b0, A_MT_HI, 32'd0, 4'h0, ov, ord, oerr, erd, eerr, ia);
      total++;
      if (ord !== 32'd1) begin
         bad++; $display("FAIL shadow_hi: got %h required 00000001", ord);
      end
      do_req(1'b0, A_MT_LO, 32'd0, 4'h0, ov, ord, oerr, erd, eerr, ia);
      total++;
      if (ord !== erd) begin
         bad++; $display("FAIL shadow_lo2: got %h required %h", ord, erd);
      end
      do_req(1'b0, A_MT_HI, 32'd0, 4'h0, ov, ord, oerr, erd, eerr, ia);
      total++;
      if (ord !== 32'd2) begin
         bad++; $display("FAIL shadow_hi2: got %h required 00000002", ord);
      end
   endtask

   task automatic test_err();
      logic ov, oerr, eerr; logic [31:0] ord, erd; s_irq_t ia;
      logic [4:0] bad_addr [4];
      bad_addr[0] = 5'h02; bad_addr[1] = 5'h18; bad_addr[2] = 5'h11; bad_addr[3] = 5'h1C;
      for (int i = 0; i < 4; i++) begin
         do_req(i >= 2, bad_addr[i], 32'hFFFF_FFFF, 4'hF, ov, ord, oerr, erd, eerr, ia);
         total++;
         if ({ov, oerr, ord} !== {1'b1, 1'b1, 32'd0}) begin
            bad++; $display("FAIL err_addr_%02h: got v=%b e=%b rd=%h required v=1 e=1 rd=0", bad_addr[i], ov, oerr, ord);
         end
      end
      total++;
      if (irq_o.sw_irq !== 1'b0) begin
         bad++; $display("FAIL err_no_state_change: sw_irq got %b required 0", irq_o.sw_irq);
      end
      do_req(1'b0, A_CMP_LO, 32'd0, 4'h0, ov, ord, oerr, erd, eerr, ia);
      total++;
      if (ord !== 32'h100) begin
         bad++; $display("FAIL err_cmp_kept: got %h required 00000100", ord);
      end
   endtask

   task automatic test_hold();
      req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = A_PRESC; req_wstrb_i = 4'h0;
      resp_ready_i = 1'b0;
      cycle();
      req_we_i = 1'b1; req_addr_i = A_MSIP; req_wdata_i = 32'd1; req_wstrb_i = 4'hF;
      for (int k = 0; k < 5; k++) begin
         cycle();
         total++;
         if ({resp_valid_o, req_ready_o, resp_rdata_o, resp_err_o} !== {1'b1, 1'b0, 32'd7, 1'b0}) begin
            bad++; $display("FAIL hold_stable k=%0d: got v=%b rdy=%b rd=%h e=%b required v=1 rdy=0 rd=7 e=0", k, resp_valid_o, req_ready_o, resp_rdata_o, resp_err_o);
         end
      end
      req_valid_i = 1'b0;
      resp_ready_i = 1'b1;
      cycle();
      total++;
      if ({resp_valid_o, req_ready_o, irq_o.sw_irq} !== 3'b010) begin
         bad++; $display("FAIL hold_release: got v=%b rdy=%b sw=%b required v=0 rdy=1 sw=0", resp_valid_o, req_ready_o, irq_o.sw_irq);
      end
   endtask

   task automatic test_msip_ext();
      logic ov, oerr, eerr; logic [31:0] ord, erd; s_irq_t ia; int rise_k;
      do_req(1'b1, A_MSIP, 32'd1, 4'h1, ov, ord, oerr, erd, eerr, ia);
      total++;
      if (ia.sw_irq !== 1'b1) begin
         bad++; $display("FAIL msip_set: got %b required 1", ia.sw_irq);
      end
      do_req(1'b1, A_MSIP, 32'd0, 4'h0, ov, ord, oerr, erd, eerr, ia);
      total++;
      if ({oerr, irq_o.sw_irq} !== 2'b01) begin
         bad++; $display("FAIL msip_wstrb0_noop: got e=%b sw=%b required e=0 sw=1", oerr, irq_o.sw_irq);
      end
      ext_irq_i = 1'b0;
      repeat (4) cycle();
      ext_irq_i = 1'b1;
      rise_k = -1;
      for (int k = 1; k <= 6; k++) begin
         cycle();
         if (k == 1) ext_irq_i = 1'b0;
         total++;
         if (irq_o.ext_irq !== ext_hist[SYNC-1]) begin
            bad++; $display("FAIL ext_pulse k=%0d: got %b required %b", k, irq_o.ext_irq, ext_hist[SYNC-1]);
         end
         if (rise_k < 0 && irq_o.ext_irq === 1'b1) rise_k = k;
      end
      total++;
      if (rise_k != SYNC) begin
         bad++; $display("FAIL ext_latency: got %0d required %0d", rise_k, SYNC);
      end
      for (int k = 0; k < 20; k++) begin
         ext_irq_i = 1'($urandom_range(0, 1));
         cycle();
         total++;
         if (irq_o !== exp_irq()) begin
            bad++; $display("FAIL ext_random k=%0d: got %b required %b", k, irq_o, exp_irq());
         end
      end
   endtask

   task automatic test_random();
      logic ov, oerr, eerr; logic [31:0] ord, erd; s_irq_t ia;
      logic we; logic [4:0] addr; logic [31:0] wd; logic [3:0] ws;
      for (int t = 0; t < 40; t++) begin
         ext_irq_i = 1'($urandom_range(0, 1));
         repeat ($urandom_range(0, 3)) cycle();
         we   = 1'($urandom_range(0, 1));
         addr = 5'($urandom_range(0, 31));
         wd   = $urandom;
         ws   = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) addr = {addr[4:2], 2'b00};
         do_req(we, addr, wd, ws, ov, ord, oerr, erd, eerr, ia);
         total++;
         if ({ov, oerr, ord} !== {1'b1, eerr, erd}) begin
            bad++; $display("FAIL rand_resp t=%0d: got v=%b e=%b rd=%h required v=1 e=%b rd=%h", t, ov, oerr, ord, eerr, erd);
         end
         total++;
         if (irq_o !== exp_irq()) begin
            bad++; $display("FAIL rand_irq t=%0d: got %b required %b", t, irq_o, exp_irq());
         end
      end
      ext_irq_i = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic ov, oerr, eerr; logic [31:0] ord, erd; s_irq_t ia;
      do_req(1'b1, A_MSIP, 32'd1, 4'hF, ov, ord, oerr, erd, eerr, ia);
      do_req(1'b1, A_PRESC, 32'd5, 4'hF, ov, ord, oerr, erd, eerr, ia);
      req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = A_CMP_LO; resp_ready_i = 1'b0;
      cycle();
      req_valid_i = 1'b0;
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      total++;
      if ({resp_valid_o, req_ready_o, resp_rdata_o, irq_o} !== {1'b0, 1'b1, 32'd0, 3'b000}) begin
         bad++; $display("FAIL reset_mid_outputs: got v=%b rdy=%b rd=%h irq=%b", resp_valid_o, req_ready_o, resp_rdata_o, irq_o);
      end
      @(negedge clk);
      rst = 1'b1;
      resp_ready_i = 1'b1;
      do_req(1'b0, A_CMP_LO, 32'd0, 4'h0, ov, ord, oerr, erd, eerr, ia);
      total++;
      if (ord !== 32'hFFFF_FFFF) begin
         bad++; $display("FAIL reset_mid_cmp: got %h required ffffffff", ord);
      end
      do_req(1'b0, A_PRESC, 32'd0, 4'h0, ov, ord, oerr, erd, eerr, ia);
      total++;
      if (ord !== 32'd0) begin
         bad++; $display("FAIL reset_mid_presc: got %h required 0", ord);
      end
      do_req(1'b0, A_MSIP, 32'd0, 4'h0, ov, ord, oerr, erd, eerr, ia);
      total++;
      if (ord !== 32'd0) begin
         bad++; $display("FAIL reset_mid_msip: got %h required 0", ord);
      end
      do_req(1'b0, A_MT_LO, 32'd0, 4'h0, ov, ord, oerr, erd, eerr, ia);
      total++;
      if (ord !== erd || ord > 32'd16) begin
         bad++; $display("FAIL reset_mid_mtime: got %h required %h", ord, erd);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_timer();
      test_presc();
      test_shadow();
      test_err();
      test_hold();
      test_msip_ext();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
